// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_event block.
// Long-press detection is enabled by defining DEBOUNCE_LONG_PRESS_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } lp_state_e;

  // Counter width for a modulus/limit of v, never narrower than one bit.
  function automatic int cnt_width(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, N-sample filter, edge pulses, sticky flag.
// Long-press FSM is built only when DEBOUNCE_LONG_PRESS_EN is defined.
//
//   state      | meaning
//   ST_IDLE    | debounced level low, waiting for a press
//   ST_PRESSED | level high, counting sample ticks toward HOLD_TICKS
//   ST_HELD    | long press already reported, waiting for release
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_VALUE  = 1'b0,
  parameter int HOLD_TICKS  = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic in_i,
  input  logic event_clr_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic event_flag_o,
  output logic long_press_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [N-1:0]           sh_q;
  logic [N-1:0]           sh_d;
  logic                   out_q, out_d;
  logic                   rise_q, fall_q, flag_q;

  assign sh_d = {sh_q[N-2:0], sync_q[SYNC_STAGES-1]};

  always_comb begin
    out_d = out_q;
    if (tick_i) begin
      if (&sh_d)       out_d = 1'b1;
      else if (~|sh_d) out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT_VALUE}};
      sh_q   <= {N{INIT_VALUE}};
      out_q  <= INIT_VALUE;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      if (tick_i) sh_q <= sh_d;
      out_q  <= out_d;
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
      // Registered edges feed the flag, so a set always wins over a same-cycle clear.
      flag_q <= (flag_q & ~event_clr_i) | rise_q | fall_q;
    end
  end

  assign out_o        = out_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign event_flag_o = flag_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = cnt_width(HOLD_TICKS + 1);

  lp_state_e      state_q;
  logic [HW-1:0]  hold_q;
  logic           lp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      lp_q    <= 1'b0;
    end else begin
      lp_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (out_q) begin
            state_q <= ST_PRESSED;
            hold_q  <= '0;
          end
        end
        ST_PRESSED: begin
          if (!out_q) begin
            state_q <= ST_IDLE;
          end else if (tick_i) begin
            hold_q <= hold_q + 1'b1;
            if (hold_q == HW'(HOLD_TICKS - 1)) begin
              lp_q    <= 1'b1;
              state_q <= ST_HELD;
            end
          end
        end
        ST_HELD: begin
          if (!out_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign long_press_o = lp_q;
`else
  assign long_press_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_event.sv
// Multi-channel debouncer/event detector with one shared sample prescaler.
// Define DEBOUNCE_LONG_PRESS_EN to enable per-channel long-press pulses.
module debounce_event
  import debounce_pkg::*;
#(
  parameter int WIDTH       = 13,
  parameter int N           = 4,
  parameter int RATE        = 125000,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT_VALUE  = 1'b0,
  parameter int HOLD_TICKS  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] event_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] event_flag,
  output logic             tick,
  output logic [WIDTH-1:0] long_press
);

  localparam int CW = cnt_width(RATE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;
  logic          wrap;

  // With RATE=1 the counter is stuck at zero, so wrap (and tick) is every cycle.
  assign wrap  = (cnt_q == CW'(RATE - 1));
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= wrap;
    end
  end

  assign tick = tick_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .N           (N),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_VALUE  (INIT_VALUE),
      .HOLD_TICKS  (HOLD_TICKS)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_i       (tick_q),
      .in_i         (in[g]),
      .event_clr_i  (event_clr[g]),
      .out_o        (out[g]),
      .rise_o       (rise[g]),
      .fall_o       (fall[g]),
      .event_flag_o (event_flag[g]),
      .long_press_o (long_press[g])
    );
  end

endmodule

// File: tb/tb_debounce_event.sv
// Directed bench for debounce_event (WIDTH=4, N=4, RATE=4, HOLD_TICKS=8).
// Long-press steps follow DEBOUNCE_LONG_PRESS_EN.
module tb_debounce_event;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n  = 1'b0;
  logic [3:0] in_v   = 4'h0;
  logic [3:0] clr_v  = 4'h0;
  logic [3:0] out_w, rise_w, fall_w, flag_w, lp_w;
  logic       tick_w;

  int checks   = 0;
  int failures = 0;
  int rise_cnt[4];
  int fall_cnt[4];
  int lp_cnt[4];
  logic [3:0] out_or   = 4'h0;
  logic [3:0] lp_or    = 4'h0;
  logic [3:0] both_err = 4'h0;
  int n;

  debounce_event #(
    .WIDTH(4), .N(4), .RATE(4), .SYNC_STAGES(2), .INIT_VALUE(1'b0), .HOLD_TICKS(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_v),
    .event_clr  (clr_v),
    .out        (out_w),
    .rise       (rise_w),
    .fall       (fall_w),
    .event_flag (flag_w),
    .tick       (tick_w),
    .long_press (lp_w)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_acc();
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
      lp_cnt[i]   = 0;
    end
    out_or = 4'h0;
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rise_w[i] === 1'b1) rise_cnt[i]++;
      if (fall_w[i] === 1'b1) fall_cnt[i]++;
      if (lp_w[i] === 1'b1)   lp_cnt[i]++;
    end
    out_or   = out_or | out_w;
    lp_or    = lp_or | lp_w;
    both_err = both_err | (rise_w & fall_w);
  endtask

  task automatic cycles(input int k);
    repeat (k) cyc();
  endtask

  task automatic wait_out(input string tag, input logic [3:0] m, input logic [3:0] v, input int budget);
    int w;
    w = 0;
    while (((out_w & m) !== (v & m)) && (w < budget)) begin
      cyc();
      w++;
    end
    check(tag, {28'h0, out_w & m}, {28'h0, v & m});
  endtask

  task automatic wait_rise3(input string tag);
    int w;
    w = 0;
    while ((rise_w[3] !== 1'b1) && (w < 19)) begin
      cyc();
      w++;
    end
    check(tag, {31'h0, rise_w[3]}, 32'h1);
  endtask

  initial begin
    clear_acc();
    // 1: reset with all pins high, then release
    in_v = 4'hF;
    cycles(3);
    check("rst_out",  {28'h0, out_w},  32'h0);
    check("rst_rise", {28'h0, rise_w}, 32'h0);
    check("rst_fall", {28'h0, fall_w}, 32'h0);
    check("rst_flag", {28'h0, flag_w}, 32'h0);
    check("rst_tick", {31'h0, tick_w}, 32'h0);
    check("rst_lp",   {28'h0, lp_w},   32'h0);
    clear_acc();
    rst_n = 1'b1;
    wait_out("t1_out_high", 4'hF, 4'hF, 19);
    cycles(3);
    for (int i = 0; i < 4; i++) check("t1_rise_once", rise_cnt[i], 32'd1);
    check("t1_no_fall", fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 32'd0);
    check("t1_flag", {28'h0, flag_w}, 32'hF);
    check("t1_rise_gone", {28'h0, rise_w}, 32'h0);

    // bring everything low and clear the flags
    clear_acc();
    in_v = 4'h0;
    wait_out("prep_out_low", 4'hF, 4'h0, 19);
    cycles(2);
    check("prep_falls", fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 32'd4);
    clr_v = 4'hF;
    cyc();
    clr_v = 4'h0;
    cyc();
    check("prep_flags_clr", {28'h0, flag_w}, 32'h0);

    // 2: glitch of exactly 3 sample ticks on channel 0
    clear_acc();
    in_v[0] = 1'b1;
    cycles(12);
    in_v[0] = 1'b0;
    cycles(30);
    check("t2_out0",  {31'h0, out_or[0]}, 32'h0);
    check("t2_rise0", rise_cnt[0], 32'd0);
    check("t2_flag0", {31'h0, flag_w[0]}, 32'h0);

    // 3: chatter on channel 1 then hold high
    clear_acc();
    for (int i = 0; i < 40; i++) begin
      in_v[1] = ~in_v[1];
      cyc();
    end
    in_v[1] = 1'b1;
    wait_out("t3_out1", 4'h2, 4'h2, 19);
    cycles(20);
    check("t3_rise1_once", rise_cnt[1], 32'd1);
    check("t3_no_fall1",   fall_cnt[1], 32'd0);
    check("t3_out1_held",  {31'h0, out_w[1]}, 32'h1);

    // 4: clear coinciding with a fall on channel 2
    in_v[2] = 1'b1;
    wait_out("t4_out2_high", 4'h4, 4'h4, 19);
    cycles(3);
    clr_v = 4'hF;
    cyc();
    clr_v = 4'h0;
    cyc();
    check("t4_flags_cleared", {28'h0, flag_w}, 32'h0);
    in_v[2] = 1'b0;
    n = 0;
    while ((fall_w[2] !== 1'b1) && (n < 19)) begin
      cyc();
      n++;
    end
    check("t4_fall_seen",   {31'h0, fall_w[2]}, 32'h1);
    check("t4_flag_before", {31'h0, flag_w[2]}, 32'h0);
    clr_v[2] = 1'b1;
    cyc();
    check("t4_set_beats_clr", {31'h0, flag_w[2]}, 32'h1);
    cyc();
    check("t4_clr_alone", {31'h0, flag_w[2]}, 32'h0);
    clr_v[2] = 1'b0;

    // 5: long press on channel 3
    clear_acc();
    in_v[3] = 1'b1;
    wait_rise3("t5_rise3");
`ifdef DEBOUNCE_LONG_PRESS_EN
    n = 0;
    while ((lp_w[3] !== 1'b1) && (n < 40)) begin
      cyc();
      n++;
    end
    check("t5_lp_delay", n, 32'd32);
    cycles(60);
    check("t5_lp_single", lp_cnt[3], 32'd1);
    in_v[3] = 1'b0;
    wait_out("t5_release", 4'h8, 4'h0, 19);
    cycles(4);
    in_v[3] = 1'b1;
    wait_rise3("t5_rerise3");
    n = 0;
    while ((lp_w[3] !== 1'b1) && (n < 40)) begin
      cyc();
      n++;
    end
    check("t5_lp_redelay", n, 32'd32);
    check("t5_lp_total", lp_cnt[3], 32'd2);
`else
    cycles(60);
    check("t5_lp_never", {28'h0, lp_or}, 32'h0);
`endif

    // 6: async reset with the clock stopped
    in_v = 4'hF;
    wait_out("t6_out_all", 4'hF, 4'hF, 19);
    cycles(2);
    check("t6_flag_pre", {31'h0, flag_w[0]}, 32'h1);
    check("t6_no_both_edges", {28'h0, both_err}, 32'h0);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out",  {28'h0, out_w},  32'h0);
    check("t6_flag", {28'h0, flag_w}, 32'h0);
    check("t6_tick", {31'h0, tick_w}, 32'h0);
    check("t6_edges", {24'h0, rise_w, fall_w}, 32'h0);
    check("t6_lp",   {28'h0, lp_w},   32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
